// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled 8N1-style deserialiser with its own baud tick,
// sticky framing/overrun flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic [10:0]     dvsr,
  input  logic            rd_uart,
  input  logic            clr_err,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_W;

  localparam logic [S_W-1:0] S_MID      = S_W'(7);
  localparam logic [S_W-1:0] S_DATA_END = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- baud tick generator ----------------
  logic [10:0] tick_cnt;
  logic [10:0] dvsr_q;
  logic        tick;

  assign tick = (tick_cnt == dvsr_q);

  // Divisor is captured at each wrap so a mid-period change cannot skip the match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      dvsr_q   <= dvsr;
    end else if (tick) begin
      tick_cnt <= '0;
      dvsr_q   <= dvsr;
    end else begin
      tick_cnt <= tick_cnt + 11'd1;
    end
  end

  // ---------------- input synchroniser ----------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------- receive FSM ----------------
  state_t          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            push_req;
  logic            frame_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rxs) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_DATA_END) begin
            s_d = '0;
            b_d = {rxs, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP_END) begin
            state_d   = IDLE;
            push_req  = rxs;
            frame_set = ~rxs;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- receive FIFO ----------------
  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr, rd_ptr;
  logic              full_q, empty_q;
  logic              wr_en, rd_en, overrun_set;

  // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
  assign wr_en       = push_req & (~full_q | rd_uart);
  assign rd_en       = rd_uart & ~empty_q;
  assign overrun_set = push_req & full_q & ~rd_uart;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= b_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10: begin
          wr_ptr  <= wr_ptr + FIFO_W'(1);
          empty_q <= 1'b0;
          full_q  <= ((wr_ptr + FIFO_W'(1)) == rd_ptr);
        end
        2'b01: begin
          rd_ptr  <= rd_ptr + FIFO_W'(1);
          full_q  <= 1'b0;
          empty_q <= ((rd_ptr + FIFO_W'(1)) == wr_ptr);
        end
        2'b11: begin
          wr_ptr <= wr_ptr + FIFO_W'(1);
          rd_ptr <= rd_ptr + FIFO_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------- sticky error flags (set beats clear) ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (overrun_set)  overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
    end
  end

  assign r_data   = mem[rd_ptr];
  assign rx_empty = empty_q;
  assign rx_full  = full_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table of frames with expected flags,
// scoreboard queue of received bytes, and hand-written corner sequences.
module tb_uart_rx_fifo;
  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int FIFO_W   = 2;
  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = 48;
  localparam int NROWS    = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [10:0] dvsr = 11'd2;
  logic        rd_uart = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  r_data;
  logic        rx_empty, rx_full, frame_err, overrun_err;

  uart_rx_fifo #(.DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_W(FIFO_W)) dut (
    .clk(clk), .reset(reset), .rx(rx), .dvsr(dvsr), .rd_uart(rd_uart),
    .clr_err(clr_err), .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int unsigned last_push_cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned ph = 0;
  logic prev_empty = 1'b1;

  // Cycle in which rx_empty is first seen low after being high.
  always @(negedge clk) begin
    if (prev_empty === 1'b1 && rx_empty === 1'b0) last_push_cyc = cyc;
    prev_empty = rx_empty;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ferr;
    logic       exp_oerr;
  } vec_t;
  vec_t vec [NROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
    logic [7:0] d;
    d = data;
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clks(BIT_CLKS);
    end else begin
      rx = 1'b0;
      wait_clks(30);
      rx = 1'b1;
      wait_clks(BIT_CLKS - 30);
    end
    wait_clks(40);
    if (stop_ok && exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic pop_check(input string name);
    check({name, "_nonempty"}, {31'd0, rx_empty}, 32'd0);
    if (exp_q.size() > 0) begin
      check(name, {24'd0, r_data}, {24'd0, exp_q.pop_front()});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: got r_data=%0h expected no entry", name, r_data);
    end
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_row(input int i);
    logic was_empty;
    int unsigned lat;
    was_empty = (exp_q.size() == 0);
    send_frame(vec[i].data, vec[i].stop_ok);
    check($sformatf("row%0d_empty", i), {31'd0, rx_empty},    {31'd0, vec[i].exp_empty});
    check($sformatf("row%0d_full", i),  {31'd0, rx_full},     {31'd0, vec[i].exp_full});
    check($sformatf("row%0d_ferr", i),  {31'd0, frame_err},   {31'd0, vec[i].exp_ferr});
    check($sformatf("row%0d_oerr", i),  {31'd0, overrun_err}, {31'd0, vec[i].exp_oerr});
    if (was_empty && vec[i].stop_ok) begin
      // 456 clocks of ticks plus the 2-clock synchroniser, +/-3 for tick phase
      lat = last_push_cyc - start_cyc;
      checks++;
      if (lat < 455 || lat > 461) begin
        errors++;
        $display("FAIL row%0d_latency: got %0d clocks expected 455..461", i, lat);
      end
    end
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, target;
    int guard;

    vec[0]  = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{8'hAB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{8'hAC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[12] = '{8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[13] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset and idle line
    wait_clks(5);
    reset = 1'b1;
    wait_clks(1000);
    check("idle_empty", {31'd0, rx_empty},    32'd1);
    check("idle_full",  {31'd0, rx_full},     32'd0);
    check("idle_ferr",  {31'd0, frame_err},   32'd0);
    check("idle_oerr",  {31'd0, overrun_err}, 32'd0);
    check("idle_nopush", last_push_cyc, 32'd0);

    // Three frames in order, then drain
    for (int i = 0; i < 3; i++) run_row(i);
    ph = (last_push_cyc - 1) % 3;
    for (int i = 0; i < 3; i++) pop_check($sformatf("drain_a%0d", i));
    check("drain_a_empty", {31'd0, rx_empty}, 32'd1);

    // Short low glitch: start rejected at the start-bit centre
    @(negedge clk);
    rx = 1'b0;
    wait_clks(9);
    rx = 1'b1;
    wait_clks(300);
    check("glitch_empty", {31'd0, rx_empty},  32'd1);
    check("glitch_ferr",  {31'd0, frame_err}, 32'd0);

    // Bad stop bit: sticky frame error until clr_err
    run_row(3);
    wait_clks(200);
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);
    pulse_clr();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Fill to full, overrun on the fifth, drain with pointer wrap
    for (int i = 4; i < 9; i++) run_row(i);
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain_b%0d", i));
    check("drain_b_empty", {31'd0, rx_empty}, 32'd1);
    pulse_clr();
    check("oerr_cleared", {31'd0, overrun_err}, 32'd0);

    // Refill, then a push that coincides with a pop while full
    for (int i = 9; i < 13; i++) run_row(i);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_clks(2);
        c0 = start_cyc + 3;
        while ((c0 % 3) != ph) c0++;
        target = c0 + 453;
        guard = 0;
        while (cyc != target && guard < 2000) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 2000) begin
          checks++;
          errors++;
          $display("FAIL coincide_wait: got cycle %0d expected %0d", cyc, target);
        end
        pop_check("coincide_pop");
      end
    join
    check("coincide_full", {31'd0, rx_full},     32'd1);
    check("coincide_oerr", {31'd0, overrun_err}, 32'd0);
    for (int i = 0; i < 2; i++) pop_check($sformatf("drain_c%0d", i));

    // Leave entries and a frame error pending, then reset mid-frame
    run_row(13);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b0; wait_clks(BIT_CLKS);
    rx = 1'b0; wait_clks(BIT_CLKS);
    rx = 1'b1; wait_clks(BIT_CLKS);
    rx = 1'b1; wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(20);
    reset = 1'b0;
    wait_clks(3);
    check("rst_empty", {31'd0, rx_empty},    32'd1);
    check("rst_full",  {31'd0, rx_full},     32'd0);
    check("rst_ferr",  {31'd0, frame_err},   32'd0);
    check("rst_oerr",  {31'd0, overrun_err}, 32'd0);
    wait_clks(27);
    check("rst_hold_empty", {31'd0, rx_empty}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    wait_clks(200);
    check("post_rst_empty", {31'd0, rx_empty},  32'd1);
    check("post_rst_ferr",  {31'd0, frame_err}, 32'd0);
    send_frame(8'h81, 1'b1);
    pop_check("post_rst_byte");
    check("post_rst_drained", {31'd0, rx_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
